// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and common defaults.
package fifo_pkg;

  localparam int SYNC_STAGES_DEFAULT = 2;

  // Conversion helpers work on a wide word; callers zero-extend in and
  // size-cast out, which is exact because zero upper bits stay zero.
  localparam int GRAY_W = 32;

  function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
    logic [GRAY_W-1:0] b;
    b[GRAY_W-1] = g[GRAY_W-1];
    for (int i = GRAY_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-bit flop-chain synchroniser for a Gray-coded pointer crossing
// clock domains. The first stage samples the raw input with no logic ahead.
module sync_ff
  import fifo_pkg::*;
#(
  parameter int Width  = 1,
  parameter int Stages = SYNC_STAGES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] chain_q [Stages];

  // Shift the asynchronous input through the chain, clearing it on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Stages; i++) begin
        chain_q[i] <= '0;
      end
    end else begin
      chain_q[0] <= d;
      for (int i = 1; i < Stages; i++) begin
        chain_q[i] <= chain_q[i-1];
      end
    end
  end

  assign q = chain_q[Stages-1];

endmodule

// File: rtl/wr_ptr_full.sv
// Write-domain control of the async FIFO: write pointer, RAM write address,
// full / almost-full / level against the synchronised read pointer, and a
// sticky overflow flag.
module wr_ptr_full
  import fifo_pkg::*;
#(
  parameter int Depth         = 8,
  parameter int PtrWidth      = $clog2(Depth),
  parameter int SyncStages    = SYNC_STAGES_DEFAULT,
  parameter int AlmostFullThr = Depth - 2
) (
  input  logic                clk_wr,
  input  logic                rst,
  input  logic                i_wr_en,
  input  logic [PtrWidth:0]   i_rd_gray_ptr,
  input  logic                i_clr_overflow,
  output logic [PtrWidth-1:0] o_wr_ptr,
  output logic [PtrWidth:0]   o_wr_gray_ptr,
  output logic                o_wr_full,
  output logic                o_wr_almost_full,
  output logic [PtrWidth:0]   o_wr_level,
  output logic                o_wr_overflow
);

  typedef logic [PtrWidth:0] ptr_t;

  localparam ptr_t AF_THR = ptr_t'(AlmostFullThr);

  if ((Depth < 4) || ((Depth & (Depth - 1)) != 0)) begin : g_bad_depth
    $error("wr_ptr_full: Depth must be a power of two >= 4");
  end
  if (SyncStages < 2) begin : g_bad_sync
    $error("wr_ptr_full: SyncStages must be >= 2");
  end
  if ((AlmostFullThr < 1) || (AlmostFullThr > Depth)) begin : g_bad_thr
    $error("wr_ptr_full: AlmostFullThr must be in 1..Depth");
  end

  ptr_t wbin;
  ptr_t wbin_next;
  ptr_t wgray_next;
  ptr_t rq_sync;
  ptr_t rbin_sync;
  ptr_t level_next;
  logic wr_accept;
  logic full_next;

  // Read-domain Gray pointer enters through a dedicated synchroniser.
  sync_ff #(
    .Width  (PtrWidth + 1),
    .Stages (SyncStages)
  ) u_rd_sync (
    .clk (clk_wr),
    .rst (rst),
    .d   (i_rd_gray_ptr),
    .q   (rq_sync)
  );

  // Next-state pointer arithmetic; full compares the next Gray write pointer
  // with the read pointer whose two MSBs are inverted (one lap ahead).
  always_comb begin
    wr_accept  = i_wr_en && !o_wr_full;
    wbin_next  = wbin + ptr_t'(wr_accept);
    wgray_next = ptr_t'(bin2gray(GRAY_W'(wbin_next)));
    rbin_sync  = ptr_t'(gray2bin(GRAY_W'(rq_sync)));
    full_next  = (wgray_next == {~rq_sync[PtrWidth:PtrWidth-1], rq_sync[PtrWidth-2:0]});
    level_next = wbin_next - rbin_sync;
  end

  // Pointer and status registers; the synchronised read pointer lags the
  // true one, so level and full can only over-report occupancy.
  always_ff @(posedge clk_wr or posedge rst) begin
    if (rst) begin
      wbin             <= '0;
      o_wr_gray_ptr    <= '0;
      o_wr_full        <= 1'b0;
      o_wr_almost_full <= 1'b0;
      o_wr_level       <= '0;
    end else begin
      wbin             <= wbin_next;
      o_wr_gray_ptr    <= wgray_next;
      o_wr_full        <= full_next;
      o_wr_almost_full <= (level_next >= AF_THR);
      o_wr_level       <= level_next;
    end
  end

  // Sticky overflow: a write attempted while full sets it and beats a clear.
  always_ff @(posedge clk_wr or posedge rst) begin
    if (rst) begin
      o_wr_overflow <= 1'b0;
    end else if (i_wr_en && o_wr_full) begin
      o_wr_overflow <= 1'b1;
    end else if (i_clr_overflow) begin
      o_wr_overflow <= 1'b0;
    end
  end

  // RAM write address is the registered binary pointer, so a write uses the
  // address held before its own increment.
  assign o_wr_ptr = wbin[PtrWidth-1:0];

endmodule

// File: tb/tb_wr_ptr_full.sv
// Bench for wr_ptr_full: directed scenarios plus random traffic, checked
// against an occupancy-count model (writes accepted minus reads seen).
module tb_wr_ptr_full;

  localparam int DEPTH = 8;
  localparam int PW    = 3;
  localparam int S     = 2;
  localparam int THR_A = DEPTH - 2;
  localparam int THR_B = 3;

  logic          clk_wr = 1'b0;
  logic          rst;
  logic          wr_en;
  logic          clr;
  logic [PW:0]   rd_gray;

  logic [PW-1:0] a_ptr,  b_ptr;
  logic [PW:0]   a_gray, b_gray;
  logic          a_full, b_full;
  logic          a_af,   b_af;
  logic [PW:0]   a_lvl,  b_lvl;
  logic          a_ovf,  b_ovf;

  wr_ptr_full #(.Depth(DEPTH), .SyncStages(S)) dut_a (
    .clk_wr           (clk_wr),
    .rst              (rst),
    .i_wr_en          (wr_en),
    .i_rd_gray_ptr    (rd_gray),
    .i_clr_overflow   (clr),
    .o_wr_ptr         (a_ptr),
    .o_wr_gray_ptr    (a_gray),
    .o_wr_full        (a_full),
    .o_wr_almost_full (a_af),
    .o_wr_level       (a_lvl),
    .o_wr_overflow    (a_ovf)
  );

  wr_ptr_full #(.Depth(DEPTH), .SyncStages(S), .AlmostFullThr(THR_B)) dut_b (
    .clk_wr           (clk_wr),
    .rst              (rst),
    .i_wr_en          (wr_en),
    .i_rd_gray_ptr    (rd_gray),
    .i_clr_overflow   (clr),
    .o_wr_ptr         (b_ptr),
    .o_wr_gray_ptr    (b_gray),
    .o_wr_full        (b_full),
    .o_wr_almost_full (b_af),
    .o_wr_level       (b_lvl),
    .o_wr_overflow    (b_ovf)
  );

  always #5 clk_wr = ~clk_wr;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: counts of accepted writes and issued reads.
  int          m_wr;
  int          m_rd;
  int          m_occ;
  bit          m_full;
  bit          m_ovf;
  int          hist[$];
  logic [PW:0] prev_gray;

  function automatic int gray_of(input int v);
    return v ^ (v >> 1);
  endfunction

  task automatic model_reset();
    m_wr   = 0;
    m_rd   = 0;
    m_occ  = 0;
    m_full = 1'b0;
    m_ovf  = 1'b0;
    hist.delete();
    for (int i = 0; i < S; i++) hist.push_back(0);
    prev_gray = '0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ptr"},  32'(a_ptr),  0);
    chk({tag, "_gray"}, 32'(a_gray), 0);
    chk({tag, "_full"}, 32'(a_full), 0);
    chk({tag, "_af"},   32'(a_af),   0);
    chk({tag, "_lvl"},  32'(a_lvl),  0);
    chk({tag, "_ovf"},  32'(a_ovf),  0);
    chk({tag, "_b_af"}, 32'(b_af),   0);
  endtask

  // Drive w/clr and the current read count, take one edge, advance the
  // model and compare every output on the following falling edge.
  task automatic step(input bit w, input bit c);
    int  rd_used;
    bit  acc;
    wr_en   = w;
    clr     = c;
    rd_gray = (PW+1)'(gray_of(m_rd % (2*DEPTH)));
    @(posedge clk_wr);
    rd_used = hist.pop_front();
    hist.push_back(m_rd);
    acc = w && !m_full;
    if (w && m_full) m_ovf = 1'b1;
    else if (c)      m_ovf = 1'b0;
    m_wr   = m_wr + int'(acc);
    m_occ  = m_wr - rd_used;
    m_full = (m_occ == DEPTH);
    @(negedge clk_wr);
    chk("wr_ptr",    32'(a_ptr),  m_wr % DEPTH);
    chk("gray_ptr",  32'(a_gray), gray_of(m_wr % (2*DEPTH)));
    chk("gray_step", 32'($countones(a_gray ^ prev_gray)), int'(acc));
    chk("full",      32'(a_full), int'(m_full));
    chk("level",     32'(a_lvl),  m_occ);
    chk("af",        32'(a_af),   int'(m_occ >= THR_A));
    chk("ovf",       32'(a_ovf),  int'(m_ovf));
    chk("b_af",      32'(b_af),   int'(m_occ >= THR_B));
    chk("b_full",    32'(b_full), int'(m_full));
    prev_gray = a_gray;
  endtask

  task automatic do_reset(input bit w_during);
    wr_en = w_during;
    clr   = 1'b0;
    rst   = 1'b1;
    #1;
    model_reset();
    rd_gray = '0;
    check_zero("rst_async");
    @(posedge clk_wr);
    @(negedge clk_wr);
    check_zero("rst_hold");
    rst   = 1'b0;
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; clr = 1'b0; rd_gray = '0;
    model_reset();
    #2;
    do_reset(1'b0);

    // 1: fill with no reads
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0);
      if (i == 4) chk("t1_af_5th", 32'(a_af), 0);
      if (i == 5) chk("t1_af_6th", 32'(a_af), 1);
    end
    chk("t1_full",  32'(a_full), 1);
    chk("t1_level", 32'(a_lvl),  DEPTH);

    // 2: writes while full, then sticky overflow behaviour
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    chk("t2_ptr",  32'(a_ptr),  0);
    chk("t2_gray", 32'(a_gray), 32'hC);
    step(1'b0, 1'b0);
    chk("t2_ovf_hold", 32'(a_ovf), 1);
    step(1'b1, 1'b1);
    chk("t2_set_wins", 32'(a_ovf), 1);
    step(1'b0, 1'b1);
    chk("t2_cleared", 32'(a_ovf), 0);

    // 3: one read frees space after SyncStages+1 edges
    m_rd = 1;
    step(1'b0, 1'b0);
    chk("t3_full_e1", 32'(a_full), 1);
    step(1'b0, 1'b0);
    chk("t3_full_e2", 32'(a_full), 1);
    step(1'b0, 1'b0);
    chk("t3_full_e3", 32'(a_full), 0);
    chk("t3_level",   32'(a_lvl),  7);

    // 4: streaming with the reader trailing, through two pointer wraps
    do_reset(1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      m_rd = m_wr - 1;
      step(1'b1, 1'b0);
      chk("t4_no_full", 32'(a_full), 0);
    end

    // 5: async reset mid-burst at level 5
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    chk("t5_level", 32'(a_lvl), 5);
    wr_en = 1'b1;
    #2;
    do_reset(1'b1);
    step(1'b1, 1'b0);
    chk("t5_first_addr", 32'(a_ptr), 1);

    // 6: lower almost-full threshold on the second instance
    do_reset(1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("t6_af_2", 32'(b_af), 0);
    step(1'b1, 1'b0);
    chk("t6_af_3", 32'(b_af), 1);
    m_rd = 1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("t6_af_hold", 32'(b_af), 1);
    step(1'b0, 1'b0);
    chk("t6_af_drop", 32'(b_af), 0);

    // Random traffic: reader advances at most one entry per cycle
    do_reset(1'b0);
    for (int i = 0; i < 400; i++) begin
      if (($urandom_range(0, 2) != 0) && (m_rd < m_wr)) m_rd = m_rd + 1;
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wr_ptr_full.md
Name: wr_ptr_full

Overview:
Write-domain control stage of the async FIFO.
- Directly upstream of the dual-port RAM.
- Owns the write pointer and drives the RAM write address.
- Generates full, almost-full, fill level and a sticky overflow flag by comparing against the read-domain Gray pointer, which it synchronises internally.
- Exports its own Gray pointer for the read-domain synchroniser.

Parameters:
Depth, 8, FIFO entries; power of two, >= 4.
PtrWidth, $clog2(Depth), RAM address width.
SyncStages, 2, flop stages on the incoming read Gray pointer; >= 2.
AlmostFullThr, Depth-2, level at or above which o_wr_almost_full asserts; 1..Depth.

Ports:
clk_wr  input  1  write-domain clock.
rst  input  1  asynchronous, active-high reset.
i_wr_en  input  1  write request from producer.
i_rd_gray_ptr  input  PtrWidth+1  read pointer, Gray coded; asynchronous to clk_wr.
i_clr_overflow  input  1  clears the sticky overflow flag.
o_wr_ptr  output  PtrWidth  RAM write address (binary pointer LSBs).
o_wr_gray_ptr  output  PtrWidth+1  registered Gray write pointer, to read domain.
o_wr_full  output  1  FIFO full; also feeds the RAM full input.
o_wr_almost_full  output  1  level >= AlmostFullThr.
o_wr_level  output  PtrWidth+1  pessimistic fill count, 0..Depth.
o_wr_overflow  output  1  sticky: a write was attempted while full.

Behaviour:
- Reset (async assert on rst high; release synchronous to clk_wr):
  - All outputs 0.
  - Binary and Gray pointers 0.
  - All synchroniser flops 0.
- Accept condition: wr_accept = i_wr_en && !o_wr_full.
- Binary pointer wbin, PtrWidth+1 bits:
  - wbin_next = wbin + wr_accept, wrapping modulo 2^(PtrWidth+1).
  - o_wr_ptr = wbin[PtrWidth-1:0], registered.
  - The RAM write on a cycle uses the pre-increment address.
- Gray pointer: o_wr_gray_ptr <= wbin_next ^ (wbin_next >> 1), registered with no combinational output path. Exactly one bit changes per accepted write.
- Read-pointer synchroniser:
  - i_rd_gray_ptr passes through SyncStages flops; output rq_sync.
  - The first flop samples asynchronously; no logic precedes it.
  - rbin_sync is the Gray-to-binary of rq_sync, combinational.
- Full:
  - o_wr_full <= (gray(wbin_next) == {~rq_sync[PtrWidth:PtrWidth-1], rq_sync[PtrWidth-2:0]}).
  - Asserts in the same clock edge as the write that fills the FIFO.
  - Deasserts no earlier than SyncStages+1 clk_wr cycles after the read-side pointer moves.
- Level and almost-full:
  - level_next = wbin_next - rbin_sync, modulo 2^(PtrWidth+1).
  - o_wr_level <= level_next.
  - o_wr_almost_full <= (level_next >= AlmostFullThr).
  - Pessimistic by design: never under-reports occupancy; o_wr_level never exceeds Depth.
- Overflow:
  - o_wr_overflow sets on i_wr_en && o_wr_full.
  - Clears on i_clr_overflow.
  - Set wins over clear in the same cycle.
  - A rejected write does not move any pointer.
- Wrap-around:
  - After 2*Depth accepted writes, wbin returns to 0.
  - The MSB toggle distinguishes full from empty; Gray adjacency holds across the wrap.
- Simultaneous write and read-pointer update while full:
  - The write is rejected (flag still 1 this cycle).
  - The flag drops only after the synchronised pointer shows space.
- Reset mid-operation: pointers and flags return to 0 immediately. A write with i_wr_en high during reset is ignored.

Decomposition:
- Shared package fifo_pkg:
  - function gray2bin(logic [N:0]) and function bin2gray, parameterised via let or width-generic function.
  - typedef for the pointer (logic [PtrWidth:0]) as a parameterised type in the module.
  - localparam default SyncStages = 2.
- Sub-module: sync_ff (SyncStages-deep multi-bit synchroniser, same clock/reset convention). The read-side counterpart reuses it.

Test Plan:
1. Reset, then 8 writes with no reads (Depth=8, i_rd_gray_ptr=0) -> o_wr_ptr steps 1..7,0; o_wr_full=1 on the edge of the 8th write; o_wr_level=8; o_wr_almost_full=1 after the 6th write.
2. While full, i_wr_en=1 for 3 cycles -> o_wr_ptr stays 0; o_wr_gray_ptr stays 4'b1100; o_wr_overflow=1 and remains 1 until i_clr_overflow; set-and-clear in the same cycle leaves it 1.
3. From full, drive i_rd_gray_ptr=4'b0001 (1 read) -> o_wr_full=0 exactly SyncStages+1 cycles later; o_wr_level=7.
4. Continuous write with the read pointer tracking at level 4 for 40 writes -> wbin wraps twice; each o_wr_gray_ptr change flips exactly 1 bit; o_wr_full never asserts.
5. Assert rst asynchronously mid-burst at level 5 -> all outputs 0 before the next clk_wr edge; the first write after release goes to address 0.
6. AlmostFullThr=3: write 2 -> almost_full=0; write 3rd -> almost_full=1 on the same edge; read pointer advances by 1 -> almost_full=0 after SyncStages+1 cycles.
